// File: rtl/special_walls_arbiter.sv
// ---------------------------------------------------------------------------
// special_walls_arbiter
//
// Shares one combinational special-walls ROM (ROWS rows x COLS bits, 1 = wall)
// among NUM_REQ requesters. One request is granted per cycle. The granted
// (row, col) is registered in stage A, which also drives the ROM address.
// Stage B extracts the cell bit from the ROM row and returns it to the winner.
// Cells outside the map read as walls.
//
// Handshake: a requester raises req_valid[i] and holds row/col stable until
// it sees req_ready[i]. The request is accepted on the rising edge that ends
// the cycle in which valid & ready are both high. The matching response is
// a one-cycle pulse on rsp_valid[i] two cycles after the grant cycle, and
// rsp_wall carries the cell bit in that cycle. rsp_wall holds otherwise.
//
// Optional feature macro: SPECIAL_WALLS_PRIO0_EN
//   defined   : requester 0 has strict priority and does not move rr_ptr;
//   undefined : pure round-robin over all requesters.
//
// Ports:
//   Clk        in   system clock, rising edge
//   Reset_n    in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]        per-requester request
//   req_row    in   [NUM_REQ*ROW_W]  packed rows, requester i at [i*ROW_W +: ROW_W]
//   req_col    in   [NUM_REQ*COL_W]  packed cols, requester i at [i*COL_W +: COL_W]
//   req_ready  out  [NUM_REQ]        one-hot grant (combinational)
//   rsp_valid  out  [NUM_REQ]        one-hot response pulse
//   rsp_wall   out  1                looked-up cell bit
//   rom_addr   out  [ROW_W]          ROM row address
//   rom_data   in   [COLS]           ROM row data, col 0 at MSB
// ---------------------------------------------------------------------------
module special_walls_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ROWS    = 105,
    parameter int COLS    = 326,
    parameter int ROW_W   = 7,
    parameter int COL_W   = 9
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*ROW_W-1:0] req_row,
    input  logic [NUM_REQ*COL_W-1:0] req_col,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic                     rsp_wall,
    output logic [ROW_W-1:0]         rom_addr,
    input  logic [COLS-1:0]          rom_data
);

    localparam int PTR_W = $clog2(NUM_REQ);

    // Round-robin pointer
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

    // Stage A: accepted request
    logic               a_valid_q, a_valid_d;
    logic [PTR_W-1:0]   a_id_q, a_id_d;
    logic [COL_W-1:0]   a_col_q, a_col_d;
    logic               a_oor_q, a_oor_d;
    logic [ROW_W-1:0]   rom_addr_q, rom_addr_d;

    // Stage B: response
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic               rsp_wall_q, rsp_wall_d;

    // Arbitration results
    logic               gnt_any;
    logic [PTR_W-1:0]   gnt_id;
    logic               prio_hit;
    logic               rr_any;
    logic [PTR_W-1:0]   rr_id;
    int                 rr_idx;
    logic [ROW_W-1:0]   sel_row;
    logic [COL_W-1:0]   sel_col;
    logic               sel_oor;
    logic [COL_W-1:0]   bit_idx;

    // Round-robin scan: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        rr_any = 1'b0;
        rr_id  = '0;
        rr_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!rr_any && req_valid[rr_idx]) begin
                rr_any = 1'b1;
                rr_id  = PTR_W'(rr_idx);
            end
        end
    end

`ifdef SPECIAL_WALLS_PRIO0_EN
    assign prio_hit = req_valid[0];
`else
    assign prio_hit = 1'b0;
`endif

    // No grants while reset is asserted, so nothing is accepted into a
    // pipeline that is being cleared.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        if (Reset_n) begin
            if (prio_hit) begin
                gnt_any = 1'b1;
                gnt_id  = '0;
            end else begin
                gnt_any = rr_any;
                gnt_id  = rr_id;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (gnt_any) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign sel_row = req_row[int'(gnt_id)*ROW_W +: ROW_W];
    assign sel_col = req_col[int'(gnt_id)*COL_W +: COL_W];
    assign sel_oor = (int'(sel_row) >= ROWS) || (int'(sel_col) >= COLS);

    // Column 0 is the MSB of the ROM row. Only used when the cell is in range.
    assign bit_idx = COL_W'(COLS - 1) - a_col_q;

    always_comb begin
        // Pointer: a priority grant to requester 0 leaves it untouched.
        rr_ptr_d = rr_ptr_q;
        if (gnt_any && !prio_hit) begin
            if (int'(gnt_id) == NUM_REQ - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_id + PTR_W'(1);
            end
        end

        // Stage A
        a_valid_d  = gnt_any;
        a_id_d     = a_id_q;
        a_col_d    = a_col_q;
        a_oor_d    = a_oor_q;
        rom_addr_d = rom_addr_q;
        if (gnt_any) begin
            a_id_d     = gnt_id;
            a_col_d    = sel_col;
            a_oor_d    = sel_oor;
            rom_addr_d = sel_oor ? '0 : sel_row;
        end

        // Stage B
        rsp_valid_d = '0;
        rsp_wall_d  = rsp_wall_q;
        if (a_valid_q) begin
            rsp_valid_d[a_id_q] = 1'b1;
            rsp_wall_d          = a_oor_q ? 1'b1 : rom_data[bit_idx];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rr_ptr_q    <= '0;
            a_valid_q   <= 1'b0;
            a_id_q      <= '0;
            a_col_q     <= '0;
            a_oor_q     <= 1'b0;
            rom_addr_q  <= '0;
            rsp_valid_q <= '0;
            rsp_wall_q  <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            a_valid_q   <= a_valid_d;
            a_id_q      <= a_id_d;
            a_col_q     <= a_col_d;
            a_oor_q     <= a_oor_d;
            rom_addr_q  <= rom_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_wall_q  <= rsp_wall_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_wall  = rsp_wall_q;
    assign rom_addr  = rom_addr_q;

endmodule
